// File: rtl/fifo_word_serializer.sv
// Pops DATA_WIDTH-bit words from a FIFO read port and emits them as OUT_WIDTH chunks on a valid/ack stream.
// Optional build macro FIFO_WORD_SERIALIZER_MSB_FIRST_EN selects MSB-chunk-first order (default LSB first).
module fifo_word_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 8
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_data_valid,
   output logic                  fifo_data_ack,
   output logic [OUT_WIDTH-1:0]  data_out,
   output logic                  data_out_valid,
   output logic                  data_out_last,
   input  logic                  data_out_ack
);

   localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
   localparam int IDX_W = $clog2(RATIO);

   typedef enum logic {EMPTY, BUSY} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] hold;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_nxt;
   logic                  last_accept;

   function automatic logic [OUT_WIDTH-1:0] chunk_of(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [IDX_W-1:0]      k);
`ifdef FIFO_WORD_SERIALIZER_MSB_FIRST_EN
      return w[DATA_WIDTH-1-int'(k)*OUT_WIDTH -: OUT_WIDTH];
`else
      return w[int'(k)*OUT_WIDTH +: OUT_WIDTH];
`endif
   endfunction

   // A new word may load while the last chunk of the previous one leaves, so no bubble.
   assign last_accept   = data_out_valid && data_out_ack && data_out_last;
   assign fifo_data_ack = rst_n && fifo_data_valid && (state == EMPTY || last_accept);
   assign idx_nxt       = idx + 1'b1;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state          <= EMPTY;
         hold           <= '0;
         idx            <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         data_out_last  <= 1'b0;
      end else if (fifo_data_ack) begin
         state          <= BUSY;
         hold           <= fifo_data;
         idx            <= '0;
         data_out       <= chunk_of(fifo_data, '0);
         data_out_valid <= 1'b1;
         data_out_last  <= 1'b0;
      end else if (state == BUSY && data_out_ack) begin
         if (data_out_last) begin
            state          <= EMPTY;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
         end else begin
            idx           <= idx_nxt;
            data_out      <= chunk_of(hold, idx_nxt);
            data_out_last <= (idx_nxt == IDX_W'(RATIO - 1));
         end
      end
   end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench for fifo_word_serializer: a FIFO model feeds words, a monitor checks every accepted chunk.
// Honours FIFO_WORD_SERIALIZER_MSB_FIRST_EN for the expected chunk order.
module tb_fifo_word_serializer;

   logic        clock = 1'b0;
   logic        rst_n;
   logic [31:0] fifo_data;
   logic        fifo_data_valid;
   logic        fifo_data_ack;
   logic [7:0]  data_out;
   logic        data_out_valid;
   logic        data_out_last;
   logic        data_out_ack;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int nchunks = 0;
   int npops   = 0;

   logic [31:0] fifo_q[$];
   logic [8:0]  exp_q[$];
   int          acc_cyc[$];
   int          pop_cyc[$];
   logic        pop_pending = 1'b0;

   fifo_word_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8)) dut (
      .clock(clock), .rst_n(rst_n),
      .fifo_data(fifo_data), .fifo_data_valid(fifo_data_valid), .fifo_data_ack(fifo_data_ack),
      .data_out(data_out), .data_out_valid(data_out_valid), .data_out_last(data_out_last),
      .data_out_ack(data_out_ack)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic refresh();
      fifo_data_valid = (fifo_q.size() != 0);
      fifo_data       = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
   endtask

   task automatic exp1(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   task automatic exp4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      exp1(a, 1'b0); exp1(b, 1'b0); exp1(c, 1'b0); exp1(d, 1'b1);
   endtask

   task automatic wait_chunks(input int target, input string name);
      for (int i = 0; i < 200; i++) begin
         @(posedge clock); #2;
         if (nchunks >= target) return;
      end
      check({name, "_timeout"}, 32'(nchunks), 32'(target));
   endtask

   // Monitor: sample away from the active edge, pop and compare on every chunk transfer.
   always @(negedge clock) begin
      pop_pending = fifo_data_valid && fifo_data_ack;
      if (pop_pending) begin
         npops++;
         pop_cyc.push_back(cyc);
      end
      if (rst_n && data_out_valid && data_out_ack) begin
         nchunks++;
         acc_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_chunk", {23'h0, data_out_last, data_out}, 32'h1ff);
         end else begin
            check("chunk", {23'h0, data_out_last, data_out}, {23'h0, exp_q.pop_front()});
         end
      end
   end

   // FIFO model: a word leaves the queue on each edge where it was acked.
   always @(posedge clock) begin
      cyc++;
      #1;
      if (pop_pending) void'(fifo_q.pop_front());
      pop_pending = 1'b0;
      refresh();
   end

   initial begin
      int base, p0;
      rst_n = 1'b0; data_out_ack = 1'b0;
      refresh();
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_valid", 32'(data_out_valid), 32'h0);
      check("rst_last",  32'(data_out_last),  32'h0);
      check("rst_data",  32'(data_out),       32'h0);
      @(posedge clock); #2; rst_n = 1'b1;

      // Empty FIFO: stays idle
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("empty_valid", 32'(data_out_valid), 32'h0);
         check("empty_ack",   32'(fifo_data_ack),  32'h0);
      end

      // Single word, ack held high
      @(posedge clock); #2;
      data_out_ack = 1'b1;
      base = nchunks; p0 = npops; acc_cyc.delete(); pop_cyc.delete();
`ifdef FIFO_WORD_SERIALIZER_MSB_FIRST_EN
      exp4(8'h44, 8'h33, 8'h22, 8'h11);
`else
      exp4(8'h11, 8'h22, 8'h33, 8'h44);
`endif
      fifo_q.push_back(32'h44332211); refresh();
      wait_chunks(base + 4, "single");
      repeat (3) @(posedge clock);
      #2;
      check("single_pops", 32'(npops - p0), 32'd1);
      if (acc_cyc.size() == 4 && pop_cyc.size() == 1) begin
         check("single_latency", 32'(acc_cyc[0]), 32'(pop_cyc[0] + 1));
         check("single_contig",  32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
      end else check("single_counts", 32'(acc_cyc.size()), 32'd4);
      @(negedge clock);
      check("single_idle", 32'(data_out_valid), 32'h0);

      // Back-to-back words, no bubble between them
      @(posedge clock); #2;
      base = nchunks; p0 = npops; acc_cyc.delete(); pop_cyc.delete();
`ifdef FIFO_WORD_SERIALIZER_MSB_FIRST_EN
      exp4(8'h44, 8'h33, 8'h22, 8'h11); exp4(8'h88, 8'h77, 8'h66, 8'h55);
`else
      exp4(8'h11, 8'h22, 8'h33, 8'h44); exp4(8'h55, 8'h66, 8'h77, 8'h88);
`endif
      fifo_q.push_back(32'h44332211); fifo_q.push_back(32'h88776655); refresh();
      wait_chunks(base + 8, "b2b");
      repeat (2) @(posedge clock);
      #2;
      check("b2b_pops", 32'(npops - p0), 32'd2);
      if (acc_cyc.size() == 8 && pop_cyc.size() == 2) begin
         check("b2b_contig",   32'(acc_cyc[7] - acc_cyc[0]), 32'd7);
         check("b2b_pop2_cyc", 32'(pop_cyc[1]), 32'(acc_cyc[3]));
      end else check("b2b_counts", 32'(acc_cyc.size()), 32'd8);

      // Backpressure on the second chunk
      base = nchunks; p0 = npops;
`ifdef FIFO_WORD_SERIALIZER_MSB_FIRST_EN
      exp4(8'h44, 8'h33, 8'h22, 8'h11);
`else
      exp4(8'h11, 8'h22, 8'h33, 8'h44);
`endif
      fifo_q.push_back(32'h44332211); refresh();
      wait_chunks(base + 1, "bp");
      data_out_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
`ifdef FIFO_WORD_SERIALIZER_MSB_FIRST_EN
         check("bp_hold_data", 32'(data_out), 32'h33);
`else
         check("bp_hold_data", 32'(data_out), 32'h22);
`endif
         check("bp_hold_last",  32'(data_out_last),  32'h0);
         check("bp_hold_valid", 32'(data_out_valid), 32'h1);
         check("bp_no_pop",     32'(fifo_data_ack),  32'h0);
      end
      @(posedge clock); #2; data_out_ack = 1'b1;
      @(negedge clock);
      @(negedge clock);
`ifdef FIFO_WORD_SERIALIZER_MSB_FIRST_EN
      check("bp_next", 32'(data_out), 32'h22);
`else
      check("bp_next", 32'(data_out), 32'h33);
`endif
      wait_chunks(base + 4, "bp_drain");
      repeat (2) @(posedge clock);
      #2;

      // Reset after the second chunk is accepted; remainder of the word must vanish
      base = nchunks;
`ifdef FIFO_WORD_SERIALIZER_MSB_FIRST_EN
      exp1(8'h44, 1'b0); exp1(8'h33, 1'b0);
`else
      exp1(8'h11, 1'b0); exp1(8'h22, 1'b0);
`endif
      fifo_q.push_back(32'h44332211); refresh();
      wait_chunks(base + 2, "rstmid");
      rst_n = 1'b0;
      fifo_q.push_back(32'hDDCCBBAA); refresh();
`ifdef FIFO_WORD_SERIALIZER_MSB_FIRST_EN
      exp4(8'hDD, 8'hCC, 8'hBB, 8'hAA);
`else
      exp4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
`endif
      @(negedge clock);
      check("rstmid_no_pop", 32'(fifo_data_ack), 32'h0);
      @(posedge clock); #2; rst_n = 1'b1;
      @(negedge clock);
      check("rstmid_valid", 32'(data_out_valid), 32'h0);
      check("rstmid_last",  32'(data_out_last),  32'h0);
      check("rstmid_data",  32'(data_out),       32'h0);
      wait_chunks(base + 6, "rstmid_next");
      repeat (3) @(posedge clock);
      #2;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("fifo_drained",     32'(fifo_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Downstream neighbour of the dual-clock FIFO; sits in the FIFO's read clock domain.
- Pops DATA_WIDTH-bit words from the FIFO read port and emits them as DATA_WIDTH/OUT_WIDTH narrower chunks on a valid/ack output stream.
- Feeds narrow sinks (byte-wide links, UART/SPI framers) without stalling the FIFO beyond the serialization rate.

Parameters:
- DATA_WIDTH, 32, width of words popped from the FIFO.
- OUT_WIDTH, 8, width of each output chunk; DATA_WIDTH must be an integer multiple of OUT_WIDTH, ratio >= 2.

Ports:
- clock  input  1  single clock; same clock that drives the FIFO read side.
- rst_n  input  1  synchronous, active-low reset.
- fifo_data  input  DATA_WIDTH  word presented by the FIFO read port.
- fifo_data_valid  input  1  FIFO has a word on fifo_data.
- fifo_data_ack  output  1  pop strobe to the FIFO; a word transfers on each cycle with fifo_data_valid && fifo_data_ack.
- data_out  output  OUT_WIDTH  current chunk.
- data_out_valid  output  1  data_out holds a valid chunk.
- data_out_last  output  1  data_out is the final chunk of its word.
- data_out_ack  input  1  sink accepts; a chunk transfers on each cycle with data_out_valid && data_out_ack.

Behaviour:
- One clock; reset is synchronous and active-low: all state updates only on the rising edge of clock, and rst_n low at an edge forces reset state.
- Reset values: data_out_valid=0, data_out_last=0, data_out=0, chunk index=0, state=EMPTY. fifo_data_ack is combinational and is 0 while rst_n is low.
- RATIO = DATA_WIDTH/OUT_WIDTH. The chunk index is $clog2(RATIO) bits wide. A holding register captures the whole word.
- States:
  - EMPTY: no word held; data_out_valid=0.
  - BUSY: a word is held; data_out_valid=1.
- fifo_data_ack = fifo_data_valid && (state==EMPTY || (data_out_valid && data_out_ack && data_out_last)). Pure combinational; the block never acks when the FIFO is not valid.
- Word accept: the holding register loads fifo_data and the index resets to 0. On the next cycle, data_out = chunk 0 and data_out_valid=1, so latency is 1 cycle from pop to first chunk.
- Chunk order: chunk k = bits [k*OUT_WIDTH +: OUT_WIDTH], with chunk 0 = LSBs.
- data_out_last = 1 exactly when index == RATIO-1.
- Backpressure: while data_out_valid && !data_out_ack, data_out, data_out_last and index hold, and fifo_data_ack=0.
- Chunk accept, not last: index increments and data_out updates to the next chunk on the next cycle.
- Chunk accept, last, with a word popped the same cycle: the new word loads and chunk 0 appears next cycle with no bubble. Full throughput is one chunk per cycle.
- Chunk accept, last, with no word available: go to EMPTY, data_out_valid=0, data_out_last=0.
- FIFO empty (fifo_data_valid=0) in EMPTY: the block stays EMPTY and outputs are idle.
- Reset mid-word: the partially sent word is discarded with no further chunks, and the FIFO is not popped during reset.
- data_out must not change while data_out_valid=1 and data_out_ack=0.

Optional Feature:
- Macro: FIFO_WORD_SERIALIZER_MSB_FIRST_EN.
- Defined: chunk k = bits [DATA_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH], i.e. MSB chunk first. data_out_last still marks the RATIO-th chunk.
- Undefined: LSB-first order as above. Handshake and timing are identical in both builds.

Test Plan:
- Single word, defaults: fifo_data=0x44332211, data_out_ack held 1 -> data_out 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after the pop; data_out_last=1 only with 0x44; fifo_data_ack pulses once.
- Back-to-back: FIFO holds 0x44332211 then 0x88776655, ack held 1 -> 8 chunks 0x11..0x88 in 8 consecutive cycles; second pop coincides with the 0x44 accept; no valid gap.
- Backpressure: data_out_ack=0 for 3 cycles while data_out=0x22 -> 0x22 and last=0 stable for those cycles; fifo_data_ack=0; 0x33 follows the first acked cycle.
- Empty FIFO: fifo_data_valid=0 for 10 cycles after reset -> data_out_valid=0, fifo_data_ack=0 throughout.
- Reset mid-word: assert rst_n=0 for 1 cycle after 0x22 is accepted -> next cycle data_out_valid=0, last=0, data_out=0; a following word 0xDDCCBBAA emits 0xAA first.
- Macro build with FIFO_WORD_SERIALIZER_MSB_FIRST_EN defined, fifo_data=0x44332211 -> data_out 0x44,0x33,0x22,0x11; last=1 with 0x11.
